// File: rtl/sm_serial_pkg.sv
// Shared definitions for the serial link (receiver and transmitter).
//   sm_rx_state_t   : receiver FSM states
//   sm_frame_bits() : bit periods per frame (start + data + parity + stop)
//   SM_*_DEF        : default link parameters, kept identical on both ends
package sm_serial_pkg;

    localparam int SM_WIDTH_DEF     = 8;
    localparam int SM_BIT_TICKS_DEF = 4;
    localparam int SM_PARITY_DEF    = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PAR,
        ST_STOP,
        ST_WAIT_IDLE
    } sm_rx_state_t;

    function automatic int sm_frame_bits(input int width, input int parity);
        return 1 + width + parity + 1;
    endfunction

endpackage

// File: rtl/sm_sync2.sv
// Two-flop synchronizer for an idle-high asynchronous line.
//   gclk   : clock
//   grst_n : synchronous active-low reset, both flops reset to 1 (idle line)
//   d      : asynchronous input
//   q      : synchronized output, 2 cycles behind d
module sm_sync2 (
    input  logic gclk,
    input  logic grst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge gclk) begin
        if (!grst_n) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/sm_serial_rx.sv
// Oversampling serial receiver with a one-deep valid/ready output buffer.
//   C          : clock
//   R_N        : synchronous active-low reset
//   RX         : serial line, idle high, asynchronous
//   DATA       : received frame data, stable while VALID
//   VALID      : buffer holds an unconsumed frame
//   READY      : consumer accepts (transfer on VALID & READY)
//   PARITY_ERR : even parity mismatch for the frame in DATA
//   FRAME_ERR  : stop bit sampled low for the frame in DATA
//   OVERRUN    : sticky, a frame arrived while the buffer was full
module sm_serial_rx
    import sm_serial_pkg::*;
#(
    parameter int WIDTH     = SM_WIDTH_DEF,
    parameter int BIT_TICKS = SM_BIT_TICKS_DEF,
    parameter int PARITY    = SM_PARITY_DEF
) (
    input  logic             C,
    input  logic             R_N,
    input  logic             RX,
    output logic [WIDTH-1:0] DATA,
    output logic             VALID,
    input  logic             READY,
    output logic             PARITY_ERR,
    output logic             FRAME_ERR,
    output logic             OVERRUN
);

    localparam int CNT_W = $clog2(BIT_TICKS);
    localparam int IDX_W = $clog2(WIDTH + 1);

    // Start bit is sampled mid-bit; every later sample is one full period on.
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(BIT_TICKS / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_TICKS - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

    logic rxs;

    sm_sync2 u_sync (
        .gclk   (C),
        .grst_n (R_N),
        .d      (RX),
        .q      (rxs)
    );

    sm_rx_state_t     state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [IDX_W-1:0] idx, idx_d;
    logic [WIDTH-1:0] shreg, shreg_d;
    logic             par_acc, par_acc_d;
    logic             perr, perr_d;
    logic             commit;
    logic             ferr_new;

    always_ff @(posedge C) begin
        if (!R_N) state <= ST_IDLE;
        else      state <= state_d;
    end

    always_comb begin
        state_d   = state;
        cnt_d     = cnt + CNT_W'(1);
        idx_d     = idx;
        shreg_d   = shreg;
        par_acc_d = par_acc;
        perr_d    = perr;
        commit    = 1'b0;
        ferr_new  = 1'b0;
        case (state)
            ST_IDLE: begin
                cnt_d = '0;
                if (!rxs) begin
                    state_d   = ST_START;
                    idx_d     = '0;
                    par_acc_d = 1'b0;
                    perr_d    = 1'b0;
                end
            end
            ST_START: begin
                if (cnt == CNT_HALF) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    // A start bit gone high by mid-bit was a glitch.
                    state_d = rxs ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (cnt == CNT_LAST) begin
                    cnt_d     = '0;
                    // LSB arrives first, so shift in from the top.
                    shreg_d   = (shreg >> 1) | (WIDTH'(rxs) << (WIDTH - 1));
                    par_acc_d = par_acc ^ rxs;
                    if (idx == IDX_LAST)
                        state_d = (PARITY != 0) ? ST_PAR : ST_STOP;
                    else
                        idx_d = idx + IDX_W'(1);
                end
            end
            ST_PAR: begin
                if (cnt == CNT_LAST) begin
                    cnt_d   = '0;
                    perr_d  = par_acc ^ rxs;
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (cnt == CNT_LAST) begin
                    cnt_d    = '0;
                    commit   = 1'b1;
                    ferr_new = ~rxs;
                    // Leaving at the stop sample gives half a bit of margin
                    // for a back-to-back start bit.
                    state_d  = rxs ? ST_IDLE : ST_WAIT_IDLE;
                end
            end
            ST_WAIT_IDLE: begin
                cnt_d = '0;
                if (rxs) state_d = ST_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge C) begin
        if (!R_N) begin
            cnt     <= '0;
            idx     <= '0;
            shreg   <= '0;
            par_acc <= 1'b0;
            perr    <= 1'b0;
        end else begin
            cnt     <= cnt_d;
            idx     <= idx_d;
            shreg   <= shreg_d;
            par_acc <= par_acc_d;
            perr    <= perr_d;
        end
    end

    // Output buffer: a commit lands if the slot is empty or is being drained
    // in the same cycle; otherwise the new frame is dropped.
    always_ff @(posedge C) begin
        if (!R_N) begin
            DATA       <= '0;
            VALID      <= 1'b0;
            PARITY_ERR <= 1'b0;
            FRAME_ERR  <= 1'b0;
            OVERRUN    <= 1'b0;
        end else if (commit) begin
            if (!VALID || READY) begin
                DATA       <= shreg;
                PARITY_ERR <= perr;
                FRAME_ERR  <= ferr_new;
                VALID      <= 1'b1;
            end else begin
                OVERRUN <= 1'b1;
            end
        end else if (VALID && READY) begin
            VALID <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sm_serial_rx.sv
// Directed bench for sm_serial_rx at WIDTH=8, BIT_TICKS=4, PARITY=1.
module tb_sm_serial_rx;

    localparam int WIDTH = 8;
    localparam int BT    = 4;

    logic             C = 1'b0;
    logic             R_N = 1'b0;
    logic             RX = 1'b1;
    logic             READY = 1'b0;
    logic [WIDTH-1:0] DATA;
    logic             VALID;
    logic             PARITY_ERR;
    logic             FRAME_ERR;
    logic             OVERRUN;

    int n_tests = 0;
    int n_fail  = 0;

    sm_serial_rx #(.WIDTH(WIDTH), .BIT_TICKS(BT), .PARITY(1)) dut (
        .C          (C),
        .R_N        (R_N),
        .RX         (RX),
        .DATA       (DATA),
        .VALID      (VALID),
        .READY      (READY),
        .PARITY_ERR (PARITY_ERR),
        .FRAME_ERR  (FRAME_ERR),
        .OVERRUN    (OVERRUN)
    );

    always #5 C = ~C;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge C);
        #1;
    endtask

    // Drives one bit period per field; returns one period after the stop
    // bit began, with RX left at the stop level.
    task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
        RX = 1'b0;
        tick(BT);
        for (int i = 0; i < WIDTH; i++) begin
            RX = d[i];
            tick(BT);
        end
        RX = p;
        tick(BT);
        RX = s;
        tick(BT);
    endtask

    task automatic wait_valid(input string tag);
        int k;
        k = 0;
        while (!VALID && k < 100) begin
            tick(1);
            k++;
        end
        if (!VALID) chk({tag, "_timeout"}, 32'(VALID), 32'd1);
    endtask

    task automatic consume();
        READY = 1'b1;
        tick(1);
        READY = 1'b0;
    endtask

    initial begin
        int vcnt;
        logic [7:0] cap;

        // Reset state
        R_N = 1'b0;
        tick(3);
        chk("rst_valid", 32'(VALID), 0);
        chk("rst_data", 32'(DATA), 0);
        chk("rst_flags", {29'd0, PARITY_ERR, FRAME_ERR, OVERRUN}, 0);
        R_N = 1'b1;
        tick(5);

        // 0xA5, even parity 0, good stop; VALID one edge after stop sample
        send_frame(8'hA5, 1'b0, 1'b1);
        chk("a5_pre_valid", 32'(VALID), 0);
        tick(1);
        chk("a5_valid", 32'(VALID), 1);
        chk("a5_data", 32'(DATA), 32'hA5);
        chk("a5_perr", 32'(PARITY_ERR), 0);
        chk("a5_ferr", 32'(FRAME_ERR), 0);
        consume();
        chk("a5_drain", 32'(VALID), 0);
        chk("a5_hold", 32'(DATA), 32'hA5);
        tick(4);

        // 0x01 with wrong parity, then 0x03 with correct parity
        send_frame(8'h01, 1'b0, 1'b1);
        wait_valid("p01");
        chk("p01_data", 32'(DATA), 32'h01);
        chk("p01_perr", 32'(PARITY_ERR), 1);
        consume();
        tick(4);
        send_frame(8'h03, 1'b0, 1'b1);
        wait_valid("p03");
        chk("p03_data", 32'(DATA), 32'h03);
        chk("p03_perr", 32'(PARITY_ERR), 0);
        consume();
        tick(4);

        // 0x5A with low stop, line held low ~20 cycles
        send_frame(8'h5A, 1'b0, 1'b0);
        tick(1);
        chk("f5a_valid", 32'(VALID), 1);
        chk("f5a_data", 32'(DATA), 32'h5A);
        chk("f5a_ferr", 32'(FRAME_ERR), 1);
        chk("f5a_perr", 32'(PARITY_ERR), 0);
        consume();
        tick(16);
        chk("f5a_low_nofrm", 32'(VALID), 0);
        RX = 1'b1;
        tick(60);
        chk("f5a_rel_nofrm", 32'(VALID), 0);
        chk("f5a_no_ovr", 32'(OVERRUN), 0);

        // Overrun: two frames, nobody reading
        send_frame(8'h11, 1'b0, 1'b1);
        tick(4);
        send_frame(8'h22, 1'b0, 1'b1);
        tick(3);
        chk("ovr_valid", 32'(VALID), 1);
        chk("ovr_data", 32'(DATA), 32'h11);
        chk("ovr_flag", 32'(OVERRUN), 1);
        consume();
        chk("ovr_drain", 32'(VALID), 0);
        chk("ovr_sticky", 32'(OVERRUN), 1);
        tick(4);

        // One-cycle glitch on an idle line
        RX = 1'b0;
        tick(1);
        RX = 1'b1;
        tick(60);
        chk("glitch_valid", 32'(VALID), 0);
        chk("glitch_data", 32'(DATA), 32'h11);

        // READY held high: exactly one VALID cycle per frame
        READY = 1'b1;
        vcnt = 0;
        cap = '0;
        send_frame(8'h80, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) begin
            if (VALID) begin
                vcnt++;
                cap = DATA;
            end
            tick(1);
        end
        READY = 1'b0;
        chk("rdy_pulses", 32'(vcnt), 1);
        chk("rdy_data", 32'(cap), 32'h80);
        tick(4);

        // Reset in the middle of data bit 4 of 0xFF
        RX = 1'b0;
        tick(BT);
        RX = 1'b1;
        tick(4 * BT + 2);
        R_N = 1'b0;
        tick(1);
        chk("mrst_valid", 32'(VALID), 0);
        chk("mrst_data", 32'(DATA), 0);
        chk("mrst_flags", {29'd0, PARITY_ERR, FRAME_ERR, OVERRUN}, 0);
        tick(1);
        R_N = 1'b1;
        tick(20);
        chk("mrst_nofrm", 32'(VALID), 0);
        send_frame(8'h3C, 1'b0, 1'b1);
        chk("c3c_pre_valid", 32'(VALID), 0);
        tick(1);
        chk("c3c_valid", 32'(VALID), 1);
        chk("c3c_data", 32'(DATA), 32'h3C);
        chk("c3c_flags", {29'd0, PARITY_ERR, FRAME_ERR, OVERRUN}, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
